// File: rtl/tri_bus_arbiter_pkg.sv
// Shared definitions for tri_bus_arbiter: FSM state encoding and the
// round-robin winner search used by rr_pick.
package tri_bus_arbiter_pkg;

  // Upper bound on channel count supported by the generic search below.
  localparam int MAX_CH = 32;
  localparam int CH_IW  = $clog2(MAX_CH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_TURN
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [CH_IW-1:0] idx;
  } pick_t;

  // First set request at or after 'start', wrapping modulo nch.
  // Scanning from the far end lets the nearest candidate overwrite the result.
  function automatic pick_t rr_winner(input logic [MAX_CH-1:0] req,
                                      input int                start,
                                      input int                nch);
    pick_t res;
    int    idx;
    res = '0;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < nch) begin
        idx = start + k;
        if (idx >= nch) idx = idx - nch;
        if (req[CH_IW'(idx)]) begin
          res.valid = 1'b1;
          res.idx   = CH_IW'(idx);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tri_bus_arbiter_if.sv
// Request/grant bundle between the producers and tri_bus_arbiter.
// The tri-state data bus itself is a plain net on the arbiter so that
// its resolution happens at the module boundary.
interface tri_bus_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4
) ();

  logic [NCH-1:0]         req;
  logic [NCH*WIDTH-1:0]   din;
  logic [NCH-1:0]         grant;
  logic [$clog2(NCH)-1:0] owner;
  logic                   bus_oe;
  logic                   busy;

  modport master (output req, din, input grant, owner, bus_oe, busy);
  modport slave  (input req, din, output grant, owner, bus_oe, busy);

endinterface

// File: rtl/tri_bus_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder. Returns the first
// requesting channel at or after start_i (wrapping), plus a valid flag.
module rr_pick
  import tri_bus_arbiter_pkg::*;
#(
  parameter int NCH = 4,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [IW-1:0]  start_i,
  output logic [IW-1:0]  idx_o,
  output logic           valid_o
);

  logic [MAX_CH-1:0] req_ext;
  pick_t             pick;

  // Widen the request vector to the package's generic width and search it.
  // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
  always_comb begin
    req_ext          = '0;
    req_ext[NCH-1:0] = req_i;
    pick             = rr_winner(req_ext, int'(start_i), NCH);
    valid_o          = pick.valid;
    idx_o            = pick.valid ? IW'(pick.idx) : '0;
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter: round-robin owner of a shared WIDTH-bit tri-state bus.
// Each tenure lasts at most MAX_HOLD cycles and is followed by TURNAROUND
// high-Z cycles before the next owner drives.
// Optional build macro: TRI_BUS_KEEPER_EN -- bus never floats; outside a
// tenure it holds the last value driven (0 after reset).
module tri_bus_arbiter
  import tri_bus_arbiter_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int NCH        = 4,
  parameter int MAX_HOLD   = 8,
  parameter int TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst,
  tri_bus_arbiter_if.slave  bus_if,
  output wire [WIDTH-1:0]   bus
);

  localparam int IW = $clog2(NCH);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURNAROUND + 1);

  state_e           state_q;
  logic [IW-1:0]    owner_q;
  logic [NCH-1:0]   grant_q;
  logic             oe_q;
  logic [HW-1:0]    hold_q;
  logic [TW-1:0]    turn_q;

  logic [IW-1:0]    start_idx;
  logic [IW-1:0]    win_idx;
  logic             win_valid;
  logic [WIDTH-1:0] owner_data;

  // Search begins one past the current/last owner, and the owner's data is muxed out.
  always_comb begin
    start_idx  = (owner_q == IW'(NCH - 1)) ? '0 : owner_q + 1'b1;
    owner_data = bus_if.din[int'(owner_q) * WIDTH +: WIDTH];
  end

  rr_pick #(.NCH(NCH), .IW(IW)) u_rr_pick (
    .req_i   (bus_if.req),
    .start_i (start_idx),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  // Arbitration FSM with registered grant, owner and drive enable.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= IW'(NCH - 1);
      grant_q <= '0;
      oe_q    <= 1'b0;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            state_q <= ST_DRIVE;
            owner_q <= win_idx;
            grant_q <= NCH'(1) << win_idx;
            oe_q    <= 1'b1;
            hold_q  <= HW'(1);
          end
        end
        ST_DRIVE: begin
          // A released request or an exhausted hold budget ends the tenure.
          if (!bus_if.req[owner_q] || hold_q == HW'(MAX_HOLD)) begin
            state_q <= ST_TURN;
            grant_q <= '0;
            oe_q    <= 1'b0;
            hold_q  <= '0;
            turn_q  <= TW'(1);
          end else begin
            hold_q  <= hold_q + 1'b1;
          end
        end
        ST_TURN: begin
          if (turn_q == TW'(TURNAROUND)) begin
            turn_q <= '0;
            if (win_valid) begin
              state_q <= ST_DRIVE;
              owner_q <= win_idx;
              grant_q <= NCH'(1) << win_idx;
              oe_q    <= 1'b1;
              hold_q  <= HW'(1);
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            turn_q <= turn_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_if.grant  = grant_q;
  assign bus_if.owner  = owner_q;
  assign bus_if.bus_oe = oe_q;
  assign bus_if.busy   = (state_q != ST_IDLE);

`ifdef TRI_BUS_KEEPER_EN
  logic [WIDTH-1:0] keep_q;

  // Capture whatever the owner drives so the bus can hold it between tenures.
  always_ff @(posedge clk) begin
    if (rst) begin
      keep_q <= '0;
    end else if (state_q == ST_DRIVE) begin
      keep_q <= owner_data;
    end
  end

  assign bus = oe_q ? owner_data : keep_q;
`else
  assign bus = oe_q ? owner_data : {WIDTH{1'bz}};
`endif

endmodule

// File: doc/tri_bus_arbiter.md
# tri_bus_arbiter

Parametrised, arbitrated tri-state bus driver: NCH requesters share one WIDTH-bit tri-state bus. A round-robin arbiter grants one channel at a time, caps each tenure at MAX_HOLD cycles, and inserts TURNAROUND high-Z cycles between owners so no two drivers ever overlap. It sits between pipeline-stage producers and the shared CPU data bus, replacing per-stage hand-gated tri-state buffers.

## Interface
- WIDTH, 4: bus / per-channel data width.
- NCH, 4: number of requesting channels (≥2).
- MAX_HOLD, 8: maximum consecutive drive cycles per grant (≥1).
- TURNAROUND, 1: high-Z cycles between tenures (≥1).
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, synchronous and active-high.
- req  in  NCH  per-channel bus request, level, held until served.
- din  in  NCH*WIDTH  channel data; channel i at din[i*WIDTH +: WIDTH].
- grant  out  NCH  one-hot (or zero) registered grant.
- owner  out  $clog2(NCH)  index of current/last owner.
- bus_oe  out  1  registered drive enable, equals |grant.
- bus  out  WIDTH  din of owner when bus_oe, else high-Z (see Configuration).
- busy  out  1  high in DRIVE or TURN.

## Operation
- States: IDLE, DRIVE, TURN.
- IDLE: if any req, next edge → DRIVE, grant winner, hold count = 1; else stay.
- Arbitration: round-robin, search starts at owner+1 mod NCH, wraps; first set req wins. After reset owner = NCH-1, so channel 0 has top priority first.
- DRIVE: bus = din[owner] combinationally (data passthrough, no extra latency); count increments each cycle.
- DRIVE exit → TURN when req[owner] low, or count == MAX_HOLD (owner's req still high is ignored; it re-arbitrates at lowest priority).
- TURN: grant = 0, bus_oe = 0, bus high-Z for exactly TURNAROUND cycles; on final TURN cycle arbitrate: any req → DRIVE with new winner, else → IDLE.
- A preempted owner still requesting wins again only if no other channel requests.
- req changes during TURN are honoured at the arbitration edge; req pulses fully inside a TURN window that drop before the final cycle are lost (requesters must hold).
- Reset (any state, mid-tenure included): next edge state IDLE, grant 0, bus_oe 0, owner NCH-1, counters 0, busy 0, bus high-Z. No TURN cycle is owed after reset.

## Timing
- Request latency from IDLE: req high at edge k → grant/bus_oe high after edge k, data on bus in cycle k+1.
- Release: req[owner] low sampled at edge k → bus_oe low after edge k; next owner drives after edge k+TURNAROUND at earliest.
- Back-to-back owners separated by exactly TURNAROUND high-Z cycles; maximum tenure MAX_HOLD cycles.
- Worst-case wait for a held request: (NCH-1)·(MAX_HOLD+TURNAROUND) cycles.
- grant and bus_oe never both high for two different channels in any cycle; bus_oe == |grant always.

## Configuration
- TRI_BUS_KEEPER_EN defined: bus never goes high-Z; in IDLE/TURN it holds the last value driven (register captured each DRIVE cycle, reset to 0). bus_oe semantics unchanged.
- Undefined: bus is high-Z whenever bus_oe is 0 (including after reset).

## Structure
- Shared package: state enum (IDLE/DRIVE/TURN), function for round-robin next-winner index.
- One sub-module: rr_pick (combinational NCH-wide rotate-priority encoder: req, start index → winner index, valid).
- Top holds FSM, hold/turn counters (widths $clog2(MAX_HOLD+1), $clog2(TURNAROUND+1)), owner register, output mux/tri-state.

## Test plan
- Reset then idle: rst 1 for 2 cycles, req=0 → grant 0, bus_oe 0, bus ZZZZ, owner 3, busy 0.
- Single request: req=0001, din[0]=4'hA held 3 cycles then dropped → grant 0001 for 3 cycles, bus=A; then 1 TURN cycle Z; IDLE.
- Contention round-robin: req=1111 held, distinct din values → grant order 0001,0010,0100,1000,0001, each 8 cycles, 1 Z cycle between, never overlap.
- Preemption: only req[2] held 20 cycles → grant 0100 for 8, Z 1, 0100 for 8, Z 1, 0100 for 2.
- Reset mid-tenure: rst during cycle 4 of channel 1 tenure → next cycle grant 0, bus Z, owner 3; req=0011 afterwards → channel 0 granted first.
- Keeper build (TRI_BUS_KEEPER_EN): channel 1 drives 4'h5 then releases → bus stays 5 through TURN/IDLE, never Z; after rst bus=0.
